// File: rtl/p1_reset_pkg.sv
// Shared types and constants for the reset sequencer.
package p1_reset_pkg;

    // Sequencer states: hold all domains, release them one by one, then run.
    typedef enum logic [1:0] {
        ST_STRETCH = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } reset_state_e;

    // Cause register layout: bits [SRC_N-1:0] are the external sources,
    // and the bits above are found by adding these offsets to SRC_N.
    localparam int CAUSE_SW_OFS  = 0;
    localparam int CAUSE_POR_OFS = 1;

    // Larger of two integers, used to size the shared stretch/stagger counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_filter.sv
// Synchronizer plus debounce for one active-low asynchronous reset request.
// The qualified flag is high while the synchronized input has been low for
// at least DEB_CYCLES consecutive samples. Any high sample clears the count.
module reset_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic clock,
    input  logic res,
    input  logic src_resn,
    output logic qualified
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_W-1:0]       deb_cnt;

    // Shift the raw request through the synchronizer; idle value is high.
    always_ff @(posedge clock) begin
        if (res) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_resn};
        end
    end

    // Count consecutive low samples, saturating at DEB_CYCLES.
    always_ff @(posedge clock) begin
        if (res) begin
            deb_cnt <= '0;
        end else if (sync_q[SYNC_STAGES-1]) begin
            deb_cnt <= '0;
        end else if (deb_cnt < DEB_W'(DEB_CYCLES)) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign qualified = (deb_cnt >= DEB_W'(DEB_CYCLES));

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: filters external reset requests, stretches the reset pulse,
// then releases DOM_N domain resets in order with a fixed stagger.
// sw_req is a single-cycle pulse with no handshake: it is acted on in the cycle
// it is high and must not be held.
module reset_seq
    import p1_reset_pkg::*;
#(
    parameter int SRC_N          = 2,
    parameter int DOM_N          = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 16,
    parameter int PULSE_CYCLES   = 8000000,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic               clock,
    input  logic               res,
    input  logic [SRC_N-1:0]   src_resn,
    input  logic [SRC_N-1:0]   src_en,
    input  logic               sw_req,
    input  logic               cause_clr,
    output logic [DOM_N-1:0]   dom_res,
    output logic               busy,
    output logic [SRC_N+1:0]   cause,
    output reset_state_e       state_dbg
);

    localparam int CNT_W   = $clog2(max_int(PULSE_CYCLES, STAGGER_CYCLES) + 1);
    localparam int CAUSE_W = SRC_N + 2;
    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CAUSE_W-1:0] CAUSE_POR    = CAUSE_W'(1) << (SRC_N + CAUSE_POR_OFS);

    reset_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DOM_N-1:0]   dom_d;
    logic [DOM_N-1:0]   dom_shift;
    logic [SRC_N-1:0]   qualified;
    logic [SRC_N-1:0]   src_act;
    logic               act_req;
    logic [CAUSE_W-1:0] set_bits;
    logic [CAUSE_W-1:0] cause_set;

    for (genvar i = 0; i < SRC_N; i++) begin : g_filter
        reset_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_filter (
            .clock     (clock),
            .res       (res),
            .src_resn  (src_resn[i]),
            .qualified (qualified[i])
        );
    end

    assign src_act   = qualified & src_en;
    assign act_req   = (|src_act) | sw_req;
    // Domains release lowest first, so the next release pattern is a left shift.
    assign dom_shift = dom_res << 1;

    // Cause bits contributed by the requests active this cycle.
    always_comb begin
        set_bits = '0;
        set_bits[SRC_N-1:0] = src_act;
        set_bits[SRC_N + CAUSE_SW_OFS] = sw_req;
    end

    // Next-state, counter and domain-reset logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dom_d     = dom_res;
        cause_set = '0;
        case (state_q)
            ST_STRETCH: begin
                dom_d = '1;
                if (act_req) begin
                    cnt_d = '0;
                end else if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    dom_d   = dom_shift;
                    state_d = (dom_shift == '0) ? ST_RUN : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (act_req) begin
                    state_d   = ST_STRETCH;
                    cnt_d     = '0;
                    dom_d     = '1;
                    cause_set = set_bits;
                end else if (cnt_q == STAGGER_LAST) begin
                    cnt_d   = '0;
                    dom_d   = dom_shift;
                    state_d = (dom_shift == '0) ? ST_RUN : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (act_req) begin
                    state_d   = ST_STRETCH;
                    dom_d     = '1;
                    cause_set = set_bits;
                end
            end
            default: begin
                state_d = ST_STRETCH;
                cnt_d   = '0;
                dom_d   = '1;
            end
        endcase
    end

    // State, counter and domain-reset registers.
    always_ff @(posedge clock) begin
        if (res) begin
            state_q <= ST_STRETCH;
            cnt_q   <= '0;
            dom_res <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dom_res <= dom_d;
        end
    end

    // Sticky cause register; a new cause in the clearing cycle survives the clear.
    always_ff @(posedge clock) begin
        if (res) begin
            cause <= CAUSE_POR;
        end else begin
            cause <= (cause_clr ? '0 : cause) | cause_set;
        end
    end

    assign busy      = (state_q != ST_RUN);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with short debounce/stretch/stagger settings.
module tb_reset_seq;
    import p1_reset_pkg::*;

    logic         clock;
    logic         res;
    logic [1:0]   src_resn;
    logic [1:0]   src_en;
    logic         sw_req;
    logic         cause_clr;
    logic [2:0]   dom_res;
    logic         busy;
    logic [3:0]   cause;
    reset_state_e state_dbg;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    reset_seq #(
        .SRC_N          (2),
        .DOM_N          (3),
        .SYNC_STAGES    (2),
        .DEB_CYCLES     (3),
        .PULSE_CYCLES   (20),
        .STAGGER_CYCLES (4)
    ) dut (
        .clock     (clock),
        .res       (res),
        .src_resn  (src_resn),
        .src_en    (src_en),
        .sw_req    (sw_req),
        .cause_clr (cause_clr),
        .dom_res   (dom_res),
        .busy      (busy),
        .cause     (cause),
        .state_dbg (state_dbg)
    );

    // Clock and reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges; inputs are driven and outputs sampled on negedges.
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the edge that zeroed the stretch counter.
    // dom_res[0] drops 20 edges later, [1] at +24, [2] and busy at +28.
    task automatic run_release(input string tag);
        logic [2:0] e;
        exp_q.delete();
        repeat (19) exp_q.push_back(3'b111);
        repeat (4)  exp_q.push_back(3'b110);
        repeat (4)  exp_q.push_back(3'b100);
        exp_q.push_back(3'b000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick(1);
            check({tag, "_dom"}, 32'(dom_res), 32'(e));
            check({tag, "_busy"}, 32'(busy), 32'(e != 3'b000));
        end
        check({tag, "_state_run"}, 32'(state_dbg), 32'(ST_RUN));
    endtask

    initial begin
        res       = 1'b1;
        src_resn  = 2'b11;
        src_en    = 2'b11;
        sw_req    = 1'b0;
        cause_clr = 1'b0;

        // Power-on reset for one edge, then the full release sequence
        tick(1);
        check("por_dom", 32'(dom_res), 32'h7);
        check("por_cause", 32'(cause), 32'h8);
        check("por_busy", 32'(busy), 32'h1);
        check("por_state", 32'(state_dbg), 32'(ST_STRETCH));
        res = 1'b0;
        run_release("por");
        check("por_cause_after", 32'(cause), 32'h8);

        // Short glitch on source 0 is filtered out
        src_resn[0] = 1'b0;
        tick(2);
        src_resn[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("glitch_dom", 32'(dom_res), 32'h0);
            check("glitch_busy", 32'(busy), 32'h0);
            check("glitch_cause", 32'(cause), 32'h8);
        end

        // Long low on source 0: asserted exactly 6 edges after first low sample
        src_resn[0] = 1'b0;
        tick(5);
        check("src0_lat_pre", 32'(dom_res), 32'h0);
        tick(1);
        check("src0_lat_dom", 32'(dom_res), 32'h7);
        check("src0_lat_busy", 32'(busy), 32'h1);
        check("src0_cause", 32'(cause), 32'h9);
        tick(4);
        src_resn[0] = 1'b1;
        tick(3);
        check("src0_hold", 32'(dom_res), 32'h7);
        run_release("src0");

        // Software request in RUN, then again in RELEASE after dom_res[0] dropped
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        check("sw_run_dom", 32'(dom_res), 32'h7);
        check("sw_run_cause", 32'(cause), 32'hd);
        check("sw_run_state", 32'(state_dbg), 32'(ST_STRETCH));
        tick(20);
        check("sw_rel_dom", 32'(dom_res), 32'h6);
        check("sw_rel_state", 32'(state_dbg), 32'(ST_RELEASE));
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        check("sw_rel_retrig_dom", 32'(dom_res), 32'h7);
        check("sw_rel_retrig_cause", 32'(cause), 32'hd);
        check("sw_rel_retrig_state", 32'(state_dbg), 32'(ST_STRETCH));
        run_release("sw");

        // Masked source 1 is ignored even when held low long enough
        src_en = 2'b01;
        src_resn[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("masked_dom", 32'(dom_res), 32'h0);
            check("masked_busy", 32'(busy), 32'h0);
        end
        src_resn[1] = 1'b1;
        tick(4);
        src_en = 2'b11;
        tick(1);
        check("masked_cause", 32'(cause), 32'hd);
        check("masked_after_en", 32'(dom_res), 32'h0);

        // Clear together with a software request: the new cause survives
        cause_clr = 1'b1;
        sw_req    = 1'b1;
        tick(1);
        cause_clr = 1'b0;
        sw_req    = 1'b0;
        check("clr_sw_cause", 32'(cause), 32'h4);
        check("clr_sw_dom", 32'(dom_res), 32'h7);
        run_release("clr_sw");
        cause_clr = 1'b1;
        tick(1);
        cause_clr = 1'b0;
        check("clr_only_cause", 32'(cause), 32'h0);

        // res at stretch counter 15 restarts the full sequence and beats cause_clr
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        check("mid_cause", 32'(cause), 32'h4);
        tick(15);
        check("mid_state", 32'(state_dbg), 32'(ST_STRETCH));
        check("mid_dom", 32'(dom_res), 32'h7);
        res       = 1'b1;
        cause_clr = 1'b1;
        sw_req    = 1'b1;
        tick(1);
        res       = 1'b0;
        cause_clr = 1'b0;
        sw_req    = 1'b0;
        check("res_mid_dom", 32'(dom_res), 32'h7);
        check("res_mid_cause", 32'(cause), 32'h8);
        check("res_mid_busy", 32'(busy), 32'h1);
        check("res_mid_state", 32'(state_dbg), 32'(ST_STRETCH));
        run_release("res_mid");

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter SRC_N, 2, number of external async reset-request sources (>=1).
REQ-002 SHALL have parameter DOM_N, 3, number of released reset domains (>=1).
REQ-003 SHALL have parameter SYNC_STAGES, 2, synchronizer flops per source (>=2).
REQ-004 SHALL have parameter DEB_CYCLES, 16, consecutive low samples qualifying a request (>=1).
REQ-005 SHALL have parameter PULSE_CYCLES, 8000000, stretch length in clock cycles; 50 ms at 160 MHz (>=1).
REQ-006 SHALL have parameter STAGGER_CYCLES, 16, gap between successive domain releases (>=1).
REQ-007 SHALL have port clock  input  1  sole clock; every flop is on its rising edge.
REQ-008 SHALL have port res  input  1  reset, synchronous, active-high (power-on/PLL-not-locked).
REQ-009 SHALL have port src_resn  input  SRC_N  async active-low reset requests (Prop plug, buttons).
REQ-010 SHALL have port src_en  input  SRC_N  per-source enable mask, quasi-static.
REQ-011 SHALL have port sw_req  input  1  synchronous single-cycle software reset request.
REQ-012 SHALL have port cause_clr  input  1  clears sticky cause register.
REQ-013 SHALL have port dom_res  output  DOM_N  active-high domain resets; dom_res[0] released first.
REQ-014 SHALL have port busy  output  1  high in every state except RUN.
REQ-015 SHALL have port cause  output  SRC_N+2  sticky cause: [SRC_N-1:0] sources, [SRC_N] software, [SRC_N+1] power-on.

Function
REQ-016 Each source SHALL pass a SYNC_STAGES flop synchronizer, then a debounce counter that clears on any high sample; qualified while count >= DEB_CYCLES.
REQ-017 Active request SHALL = OR over i of (qualified[i] & src_en[i]), OR sw_req.
REQ-018 States SHALL be STRETCH, RELEASE, RUN.
REQ-019 STRETCH: dom_res all ones; counter increments each cycle with no active request, clears to 0 on any active request (retrigger); at PULSE_CYCLES-1 go to RELEASE.
REQ-020 dom_res[0] SHALL drop the cycle after the counter reaches PULSE_CYCLES-1; dom_res[k] SHALL drop exactly STAGGER_CYCLES cycles after dom_res[k-1].
REQ-021 On release of dom_res[DOM_N-1] SHALL enter RUN; busy low in that same cycle.
REQ-022 Active request in RELEASE or RUN SHALL next cycle enter STRETCH with dom_res all ones and counter 0.
REQ-023 Source-low to dom_res asserted latency SHALL be exactly SYNC_STAGES+DEB_CYCLES+1 cycles from RUN.
REQ-024 On entry to STRETCH, cause bits of active requests SHALL be ORed into cause; cause_clr zeroes cause; a set in the same cycle as cause_clr SHALL win.
REQ-025 Counter width SHALL be $clog2(max(PULSE_CYCLES,STAGGER_CYCLES)+1); no wrap permitted.

Reset
REQ-026 On res: state STRETCH, counter 0, dom_res all ones, busy 1, cause = only power-on bit set, synchronizers and debounce counters to the idle (high / 0) value.
REQ-027 res mid-STRETCH or mid-RELEASE SHALL restart the full sequence; res overrides all other inputs including cause_clr.

Structure
REQ-028 Package p1_reset_pkg SHALL hold the state enum and cause bit-index helper constants (CAUSE_SW_OFS, CAUSE_POR_OFS offsets).
REQ-029 Per-source synchronizer plus debounce SHALL be sub-module reset_filter, instantiated SRC_N times via generate.

Verification (SRC_N=2, DOM_N=3, SYNC_STAGES=2, DEB_CYCLES=3, PULSE_CYCLES=20, STAGGER_CYCLES=4)
REQ-030 res high 1 cycle -> dom_res=3'b111, cause=4'b1000; dom_res[0] low 20 cycles after res falls, [1] at +24, [2] and busy low at +28.
REQ-031 src_resn[0] low 2 cycles in RUN -> no change to dom_res, busy, cause.
REQ-032 src_resn[0] low 10 cycles in RUN -> dom_res=3'b111 at cycle 6, cause[0]=1, dom_res[0] low 20 cycles after last qualified sample.
REQ-033 sw_req pulse after dom_res[0] released in RELEASE -> dom_res=3'b111 next cycle, cause[2]=1, full sequence restarts.
REQ-034 src_en[1]=0 and src_resn[1] low 10 cycles -> ignored; cause_clr with simultaneous sw_req -> cause=4'b0100.
REQ-035 res asserted at counter=15 in STRETCH -> counter restarts, release at 20 cycles after res falls.
